// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin arbiter and sequencer for the shared 8:1 operand/result bus.
// Grants one requester at a time, drives the mux select and presents the selected word
// to a single consumer over valid/ready. Each grant is bounded by MAX_BURST transfers.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (forced release after TIMEOUT stall cycles).
module bus_arbiter8 #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           req,
  input  logic [8*WIDTH-1:0]   in_data,
  input  logic [7:0]           in_last,
  output logic [7:0]           grant,
  output logic [2:0]           sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e      state_q, state_d;
  logic [7:0]  grant_q, grant_d;
  logic [2:0]  sel_q, sel_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [3:0]  beat_q, beat_d;

  logic        pick_found;
  logic [2:0]  pick_idx;
  logic        xfer;
  logic        burst_done;
  logic        timeout;

  // Shared 8:1 bus mux, selected by the registered sel
  always_comb begin
    out_data = in_data[sel_q*WIDTH +: WIDTH];
  end

  assign busy      = (state_q == StGrant);
  assign out_valid = busy & req[sel_q];
  assign out_last  = busy & in_last[sel_q];
  assign grant     = grant_q;
  assign sel       = sel_q;

  assign xfer       = out_valid & out_ready;
  assign burst_done = ((beat_q + 4'd1) == 4'(MAX_BURST));

  // Round-robin pick: first requester scanning from ptr upward, wrapping mod 8
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    for (int i = 0; i < 8; i++) begin
      if (!pick_found && req[ptr_q + 3'(i)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr_q + 3'(i);
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] stall_q, stall_d;

  // Stall counter: counts no-transfer GRANT cycles, cleared on transfer and outside GRANT
  always_comb begin
    stall_d = stall_q;
    timeout = 1'b0;
    if (state_q == StGrant) begin
      if (xfer) begin
        stall_d = 8'd0;
      end else if (req[sel_q]) begin
        // A dropped request is an abort, not a stall
        stall_d = stall_q + 8'd1;
        if (stall_d == 8'(TIMEOUT)) begin
          timeout = 1'b1;
        end
      end
    end else begin
      stall_d = 8'd0;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 8'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign timeout_err = timeout;
`else
  assign timeout     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state: arbitrate in IDLE, count beats and decide release in GRANT
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StGrant;
          sel_d   = pick_idx;
          grant_d = 8'd1 << pick_idx;
          beat_d  = 4'd0;
        end
      end
      StGrant: begin
        if (xfer && (beat_q != 4'hF)) begin
          beat_d = beat_q + 4'd1;
        end
        if (!req[sel_q] || timeout || (xfer && (in_last[sel_q] || burst_done))) begin
          state_d = StIdle;
          grant_d = 8'd0;
          // Released source becomes lowest priority; sel holds until next grant
          ptr_d   = sel_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 8'd0;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      beat_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
    end
  end

endmodule
